// File: rtl/spin_phase_sampler_pkg.sv
// Shared definitions for the spin phase sampler: FSM encodings, readout bit
// positions and the majority-vote spin decision.
package spin_phase_sampler_pkg;

   typedef enum logic [1:0] {
      SPS_IDLE  = 2'd0,
      SPS_FLUSH = 2'd1,
      SPS_COUNT = 2'd2,
      SPS_DONE  = 2'd3
   } sps_state_t;

   localparam int SPS_SPIN_BIT = 0;
   localparam int SPS_DONE_BIT = 1;
   localparam int SPS_BUSY_BIT = 2;
   localparam int SPS_CNT_LSB  = 16;

   // Spin is 1 when at least half of the window agreed; an exact tie gives 1.
   function automatic logic sps_decide(input logic [15:0] cnt, input int unsigned win);
      return ({1'b0, cnt, 1'b0} >= 18'(win));
   endfunction

endpackage

// File: rtl/spin_phase_sampler_if.sv
// Per-cell register slot: write strobe/data in, status readback out.
interface spin_phase_sampler_if;
   logic        wready;
   logic        wr_addr_match;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output wready, output wr_addr_match, output wdata, input rdata);
   modport slave  (input wready, input wr_addr_match, input wdata, output rdata);
endinterface

// File: rtl/spin_phase_sampler_bit_synchronizer.sv
// Multi-flop synchronizer for one asynchronous level; flops clear on reset.
module spin_phase_sampler_bit_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic i_rstn,
   input  logic i_d,
   output logic o_q
);

`ifndef SIM
   (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic [STAGES-1:0] r_sync;
`else
   logic [STAGES-1:0] r_sync;
`endif

   always_ff @(posedge clk) begin
      if (!i_rstn) r_sync <= '0;
      else         r_sync <= {r_sync[STAGES-2:0], i_d};
   end

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spin_phase_sampler.sv
// Readout stage for one oscillator cell: counts clk cycles where the cell output
// agrees with the reference over a fixed window and latches a majority spin.
//
//  state | meaning
//  IDLE  | waiting for a start write
//  FLUSH | draining stale synchronizer contents (SYNC_STAGES cycles)
//  COUNT | accumulating phase agreement over WINDOW_CYCLES samples
//  DONE  | spin latched, result readable until start or clear
module spin_phase_sampler
   import spin_phase_sampler_pkg::*;
#(
   parameter int WINDOW_CYCLES = 1024,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                 clk,
   input  logic                 axi_rstn,
   input  logic                 osc_in,
   input  logic                 ref_in,
   spin_phase_sampler_if.slave  bus
);

   localparam logic [1:0]  FLUSH_LAST = 2'(SYNC_STAGES - 1);
   localparam logic [15:0] WIN_LAST   = 16'(WINDOW_CYCLES - 1);

   sps_state_t  r_state;
   sps_state_t  w_next_state;
   logic [1:0]  r_flush_cnt;
   logic [15:0] r_win_cnt;
   logic [15:0] r_match_cnt;
   logic        r_spin;

   logic        w_osc_s;
   logic        w_ref_s;
   logic        w_match;
   logic        w_wr;
   logic        w_start;
   logic        w_clear;
   logic        w_flush_last;
   logic        w_win_last;
   logic [15:0] w_match_next;
   logic [31:0] w_rdata;
   logic        w_unused_wdata;

   spin_phase_sampler_bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_osc (
      .clk    (clk),
      .i_rstn (axi_rstn),
      .i_d    (osc_in),
      .o_q    (w_osc_s)
   );

   spin_phase_sampler_bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync_ref (
      .clk    (clk),
      .i_rstn (axi_rstn),
      .i_d    (ref_in),
      .o_q    (w_ref_s)
   );

   assign w_wr           = bus.wready & bus.wr_addr_match;
   assign w_start        = bus.wdata[0];
   assign w_clear        = bus.wdata[1];
   assign w_unused_wdata = &{1'b0, bus.wdata[31:2]};
   assign w_match        = (w_osc_s == w_ref_s);
   assign w_flush_last   = (r_flush_cnt == FLUSH_LAST);
   assign w_win_last     = (r_win_cnt == WIN_LAST);
   assign w_match_next   = r_match_cnt + {15'd0, w_match};

   always_ff @(posedge clk) begin
      if (!axi_rstn) r_state <= SPS_IDLE;
      else           r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (w_wr && w_clear) begin
         w_next_state = SPS_IDLE;
      end else begin
         case (r_state)
            SPS_IDLE:  if (w_wr && w_start) w_next_state = SPS_FLUSH;
            SPS_FLUSH: if (w_flush_last)    w_next_state = SPS_COUNT;
            SPS_COUNT: if (w_win_last)      w_next_state = SPS_DONE;
            SPS_DONE:  if (w_wr && w_start) w_next_state = SPS_FLUSH;
            default:                        w_next_state = SPS_IDLE;
         endcase
      end
   end

   // Counters and the spin latch; clear wins over start in the same write.
   always_ff @(posedge clk) begin
      if (!axi_rstn) begin
         r_flush_cnt <= '0;
         r_win_cnt   <= '0;
         r_match_cnt <= '0;
         r_spin      <= 1'b0;
      end else if (w_wr && w_clear) begin
         r_flush_cnt <= '0;
         r_win_cnt   <= '0;
         r_match_cnt <= '0;
         r_spin      <= 1'b0;
      end else begin
         case (r_state)
            SPS_IDLE, SPS_DONE: begin
               if (w_wr && w_start) begin
                  r_flush_cnt <= '0;
                  r_win_cnt   <= '0;
                  r_match_cnt <= '0;
               end
            end
            SPS_FLUSH: begin
               r_flush_cnt <= w_flush_last ? 2'd0 : r_flush_cnt + 2'd1;
            end
            SPS_COUNT: begin
               r_match_cnt <= w_match_next;
               if (w_win_last) begin
                  r_win_cnt <= '0;
                  r_spin    <= sps_decide(w_match_next, WINDOW_CYCLES);
               end else begin
                  r_win_cnt <= r_win_cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_rdata                             = '0;
      w_rdata[SPS_SPIN_BIT]               = r_spin;
      w_rdata[SPS_DONE_BIT]               = (r_state == SPS_DONE);
      w_rdata[SPS_BUSY_BIT]               = (r_state == SPS_FLUSH) || (r_state == SPS_COUNT);
      w_rdata[SPS_CNT_LSB +: 16]          = r_match_cnt;
   end

   assign bus.rdata = w_rdata;

endmodule
